// File: rtl/quad_adc_pkg.sv
// Shared constants and types for the quad ADC LVDS channel deserializer.
`timescale 1ns/1ps
package quad_adc_pkg;

    localparam int unsigned ADC_BITS         = 14;
    localparam int unsigned FRAME_BITS       = 16;
    localparam int unsigned LANES            = 2;
    localparam int unsigned CYCLES_PER_FRAME = 4;

    typedef logic [ADC_BITS-1:0] adc_sample_t;
    typedef logic [2:0]          shift_cnt_t;

    localparam shift_cnt_t SHIFT_CNT_MAX = shift_cnt_t'(CYCLES_PER_FRAME);

endpackage

// File: rtl/quad_adc_channel_interface_if.sv
// Pin-side bundle of one ADC channel: frame marker, two DDR lanes and the parallel sample output.
`timescale 1ns/1ps
interface quad_adc_channel_interface_if #(
    parameter int unsigned BITS = quad_adc_pkg::ADC_BITS
);

    logic            frame_clk;
    logic            ch_x_a;
    logic            ch_x_b;
    logic [BITS-1:0] ch_x_data;
    logic            ch_x_valid;

    // master drives the ADC pins, slave is the deserializer
    modport master (
        output frame_clk, ch_x_a, ch_x_b,
        input  ch_x_data, ch_x_valid
    );

    modport slave (
        input  frame_clk, ch_x_a, ch_x_b,
        output ch_x_data, ch_x_valid
    );

endinterface

// File: rtl/adc_ddr_lane_capture.sv
// DDR capture of one LVDS lane: one register per DATA_CLK edge.
`timescale 1ns/1ps
module adc_ddr_lane_capture (
    input  logic clk,
    input  logic rst_n,
    input  logic lane,
    output logic rise_q,
    output logic fall_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= lane;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= lane;
        end
    end

endmodule

// File: rtl/quad_adc_channel_interface.sv
// Deserializes one 2-lane DDR ADC channel into parallel samples framed by FRAME_CLK.
`timescale 1ns/1ps
module quad_adc_channel_interface #(
    parameter int unsigned BITS       = quad_adc_pkg::ADC_BITS,
    parameter int unsigned FRAME_BITS = quad_adc_pkg::FRAME_BITS
) (
    input logic                         data_clk,
    input logic                         reset_n,
    quad_adc_channel_interface_if.slave adc
);

    import quad_adc_pkg::*;

    localparam int unsigned PairBits = 2 * LANES;
    // The oldest pair shifts out each cycle and is never read, so only the rest is stored
    localparam int unsigned KeepBits = FRAME_BITS - PairBits;

    logic                  rise_a_q, fall_a_q, rise_b_q, fall_b_q;
    logic [KeepBits-1:0]   sr_q;
    logic [FRAME_BITS-1:0] sr_next;
    logic                  frame_q;
    logic                  frame_start;
    logic                  emit;
    shift_cnt_t            cnt_q, cnt_d;
    logic [BITS-1:0]       data_q;
    logic                  valid_q;

    adc_ddr_lane_capture u_lane_a (
        .clk    (data_clk),
        .rst_n  (reset_n),
        .lane   (adc.ch_x_a),
        .rise_q (rise_a_q),
        .fall_q (fall_a_q)
    );

    adc_ddr_lane_capture u_lane_b (
        .clk    (data_clk),
        .rst_n  (reset_n),
        .lane   (adc.ch_x_b),
        .rise_q (rise_b_q),
        .fall_q (fall_b_q)
    );

    always_comb begin
        sr_next     = {sr_q, rise_a_q, rise_b_q, fall_a_q, fall_b_q};
        frame_start = adc.frame_clk & ~frame_q;
        cnt_d       = (cnt_q == SHIFT_CNT_MAX) ? cnt_q : cnt_q + shift_cnt_t'(1);
        // Fewer than a frame's worth of shifts since reset means a partial sample
        emit        = frame_start && (cnt_q == SHIFT_CNT_MAX);
    end

    always_ff @(posedge data_clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q    <= '0;
            frame_q <= 1'b1;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_next[KeepBits-1:0];
            frame_q <= adc.frame_clk;
            cnt_q   <= cnt_d;
            valid_q <= emit;
            if (emit) begin
                data_q <= sr_next[FRAME_BITS-1 -: BITS];
            end
        end
    end

    assign adc.ch_x_data  = data_q;
    assign adc.ch_x_valid = valid_q;

endmodule

// File: tb/tb_quad_adc_channel_interface.sv
// Scoreboard bench for quad_adc_channel_interface driving framed DDR lane traffic.
`timescale 1ns/1ps
module tb_quad_adc_channel_interface;

    import quad_adc_pkg::*;

    typedef struct {
        logic [13:0] data;
        int unsigned gap;
    } exp_t;

    logic data_clk = 1'b0;
    logic reset_n  = 1'b1;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_valid = 0;

    quad_adc_channel_interface_if #(.BITS(ADC_BITS)) adc_bus ();

    quad_adc_channel_interface #(
        .BITS       (ADC_BITS),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .data_clk (data_clk),
        .reset_n  (reset_n),
        .adc      (adc_bus)
    );

    always #5 data_clk = ~data_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One frame, starting on a falling edge: marker at +3, pairs 1 ns before each capture edge
    task automatic send_frame(input logic [13:0] word, input logic [1:0] pad, input bit mark,
                              input bit hold, input bit expect_out, input int unsigned gap);
        exp_t e;
        if (expect_out) begin
            e.data = word;
            e.gap  = gap;
            exp_q.push_back(e);
        end
        #3 adc_bus.frame_clk = mark;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                #1;
            end else if (i == 4) begin
                #4 adc_bus.frame_clk = hold;
                #1;
            end else begin
                #5;
            end
            if (i < 7) begin
                adc_bus.ch_x_a = word[13-2*i];
                adc_bus.ch_x_b = word[12-2*i];
            end else begin
                adc_bus.ch_x_a = pad[1];
                adc_bus.ch_x_b = pad[0];
            end
        end
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge data_clk);
            cyc++;
            #1;
            if (adc_bus.ch_x_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data 0x%0h, required no valid at %0t",
                             adc_bus.ch_x_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_data", 32'(adc_bus.ch_x_data), 32'(e.data));
                    if (e.gap != 0) begin
                        check("valid_spacing", cyc - last_valid, e.gap);
                    end
                end
                last_valid = cyc;
            end
        end
    end

    initial begin
        adc_bus.frame_clk = 1'b0;
        adc_bus.ch_x_a    = 1'b0;
        adc_bus.ch_x_b    = 1'b0;
        #1 reset_n = 1'b0;
        #10;
        check("reset_data", 32'(adc_bus.ch_x_data), 32'h0);
        check("reset_valid", 32'(adc_bus.ch_x_valid), 32'h0);
        #1 reset_n = 1'b1;
        #8;

        // Basic capture: first frame carries idle zeros, then 0x2AAA and 0x2BBB
        send_frame(14'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 0);
        send_frame(14'h2AAA, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        send_frame(14'h2BBB, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        // Back-to-back extremes
        send_frame(14'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        send_frame(14'h3FFF, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        send_frame(14'h1555, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        // Lane order, pad pair carries the same lane pattern and must be ignored
        send_frame(14'h2AAA, 2'b10, 1'b1, 1'b0, 1'b1, 4);
        send_frame(14'h1555, 2'b01, 1'b1, 1'b0, 1'b1, 4);
        // FRAME_CLK held high for 8 cycles: only the first rise starts a frame
        send_frame(14'h0123, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        send_frame(14'h0456, 2'b00, 1'b1, 1'b1, 1'b0, 0);
        send_frame(14'h0789, 2'b00, 1'b0, 1'b0, 1'b1, 12);
        send_frame(14'h1ABC, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        send_frame(14'h2DEF, 2'b00, 1'b1, 1'b0, 1'b1, 4);

        // Reset mid-frame at +30, released at +12 into the next frame
        fork
            begin
                send_frame(14'h3333, 2'b00, 1'b1, 1'b0, 1'b0, 0);
                send_frame(14'h3C3C, 2'b00, 1'b1, 1'b0, 1'b0, 0);
            end
            begin
                #30 reset_n = 1'b0;
                #1;
                check("midframe_reset_data", 32'(adc_bus.ch_x_data), 32'h0);
                check("midframe_reset_valid", 32'(adc_bus.ch_x_valid), 32'h0);
                #21 reset_n = 1'b1;
            end
        join
        fork
            send_frame(14'h0F0F, 2'b00, 1'b1, 1'b0, 1'b1, 12);
            begin
                #6;
                check("no_valid_partial", 32'(adc_bus.ch_x_valid), 32'h0);
            end
        join
        send_frame(14'h2468, 2'b00, 1'b1, 1'b0, 1'b1, 4);

        // Reset released while FRAME_CLK is high
        fork
            send_frame(14'h1111, 2'b00, 1'b1, 1'b0, 1'b0, 0);
            begin
                #7 reset_n = 1'b0;
                #5 reset_n = 1'b1;
                #4;
                check("release_frame_high_valid", 32'(adc_bus.ch_x_valid), 32'h0);
                check("release_frame_high_data", 32'(adc_bus.ch_x_data), 32'h0);
            end
        join
        send_frame(14'h3A5C, 2'b00, 1'b1, 1'b0, 1'b1, 8);
        send_frame(14'h05A3, 2'b00, 1'b1, 1'b0, 1'b1, 4);
        send_frame(14'h0000, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        #50;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_samples: got %0d samples outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
